load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/load_store_unit_if.sv | 51 +++++
 rtl/lsu_lane_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared funct3 codes, FSM state type and decode helpers for
//                the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    // funct3[1:0] encodes the access size for every legal load and store.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
        logic ill;
        ill = 1'b1;
        if (store) begin
            ill = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            ill = !(funct3 == F3_B  || funct3 == F3_H  || funct3 == F3_W ||
                    funct3 == F3_BU || funct3 == F3_HU);
        end
        return ill;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_req_if / lsu_mem_if
//  Description : Core-side request/response bundle and word-memory bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_address, mem_write_data, mem_write_enable,
        input  mem_read_data
    );

    modport slave (
        input  mem_address, mem_write_data, mem_write_enable,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational load lane extract/extend and store lane merge.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[7:0];
        case (off_i)
            2'd0: w_byte = word_i[7:0];
            2'd1: w_byte = word_i[15:8];
            2'd2: w_byte = word_i[23:16];
            2'd3: w_byte = word_i[31:24];
            default: w_byte = word_i[7:0];
        endcase
        w_half = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   load_data_o = {24'd0, w_byte};
            F3_H:    load_data_o = {{16{w_half[15]}}, w_half};
            F3_HU:   load_data_o = {16'd0, w_half};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        merge_data_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (off_i)
                    2'd0: merge_data_o = {word_i[31:8], wdata_i[7:0]};
                    2'd1: merge_data_o = {word_i[31:16], wdata_i[7:0], word_i[7:0]};
                    2'd2: merge_data_o = {word_i[31:24], wdata_i[7:0], word_i[15:0]};
                    2'd3: merge_data_o = {wdata_i[7:0], word_i[23:0]};
                    default: merge_data_o = word_i;
                endcase
            end
            F3_H:    merge_data_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                             : {word_i[31:16], wdata_i[15:0]};
            F3_W:    merge_data_o = wdata_i;
            default: merge_data_o = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I load/store to word-only memory; sub-word stores via RMW.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("load_store_unit: DATA_W must be 32");
        end
    endgenerate

    lsu_state_t        state_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [31:0]       mem_write_data_q;
    logic              mem_write_enable_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_data;
    logic              w_req_err;

    assign w_req_err = is_illegal(req.req_store, req.req_funct3) |
                       is_misaligned(req.req_funct3, req.req_addr[1:0]);

    lsu_lane_align u_lane_align (
        .word_i       (mem.mem_read_data[31:0]),
        .off_i        (addr_lo_q),
        .funct3_i     (funct3_q),
        .wdata_i      (wdata_q),
        .load_data_o  (w_load_data),
        .merge_data_o (w_merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            addr_lo_q          <= 2'b00;
            funct3_q           <= 3'b000;
            wdata_q            <= 32'd0;
            mem_address_q      <= '0;
            mem_write_data_q   <= 32'd0;
            mem_write_enable_q <= 1'b0;
            rsp_valid_q        <= 1'b0;
            rsp_rdata_q        <= 32'd0;
            rsp_err_q          <= 1'b0;
        end else begin
            mem_write_enable_q <= 1'b0;
            rsp_valid_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req.req_valid) begin
                        addr_lo_q <= req.req_addr[1:0];
                        funct3_q  <= req.req_funct3;
                        wdata_q   <= req.req_wdata[31:0];
                        if (w_req_err) begin
                            // Faulting requests never touch the memory-side registers.
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            rsp_err_q     <= 1'b0;
                            mem_address_q <= {req.req_addr[ADDR_W-1:2], 2'b00};
                            if (!req.req_store) begin
                                state_q <= LOAD;
                            end else if (req.req_funct3 == F3_W) begin
                                mem_write_data_q   <= req.req_wdata[31:0];
                                mem_write_enable_q <= 1'b1;
                                state_q            <= WRITE;
                            end else begin
                                state_q <= RMW_READ;
                            end
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata_q <= w_load_data;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RMW_READ: begin
                    mem_write_data_q   <= w_merge_data;
                    mem_write_enable_q <= 1'b1;
                    state_q            <= WRITE;
                end
                WRITE: begin
                    rsp_rdata_q <= 32'd0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst_n so the core sees no acceptance while reset is held.
    assign req.req_ready        = rst_n && (state_q == IDLE);
    assign req.rsp_valid        = rsp_valid_q;
    assign req.rsp_rdata        = rsp_rdata_q;
    assign req.rsp_err          = rsp_err_q;
    assign mem.mem_address      = mem_address_q;
    assign mem.mem_write_data   = mem_write_data_q;
    assign mem.mem_write_enable = mem_write_enable_q;

endmodule
`default_nettype wire
